// File: rtl/diamond_eat_ctrl.sv
// diamond_eat_ctrl
// Per-level diamond collection controller. Once per video frame (after the
// game is active) it latches the player position and walks the level's
// diamonds one per clock, marking every diamond the player hitbox overlaps
// as eaten. Eaten flags are sticky until level_reset or Reset_n.
//
// Ports:
//   Clk            system clock
//   Reset_n        asynchronous active-low reset
//   frame_clk      vsync-derived strobe, asynchronous to Clk
//   level_reset    synchronous clear of all eaten state, aborts a scan
//   game_active    scans only start while high
//   player_x/y     player hitbox top-left corner (pixels)
//   diamond_x/y    packed diamond top-left corners, 10 bits per diamond
//   is_diamond_eat sticky per-diamond eaten flags
//   diamond_count  number of diamonds eaten
//   all_eaten      every diamond eaten (updated once per scan)
//   eat_pulse      one-cycle strobe per newly eaten diamond
//   busy           scan in progress
module diamond_eat_ctrl #(
  parameter int N_DIAMOND    = 4,
  parameter int DIAMOND_SIZE = 20,
  parameter int PLAYER_W     = 20,
  parameter int PLAYER_H     = 30
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    frame_clk,
  input  logic                    level_reset,
  input  logic                    game_active,
  input  logic [9:0]              player_x,
  input  logic [9:0]              player_y,
  input  logic [10*N_DIAMOND-1:0] diamond_x,
  input  logic [10*N_DIAMOND-1:0] diamond_y,
  output logic [N_DIAMOND-1:0]    is_diamond_eat,
  output logic [3:0]              diamond_count,
  output logic                    all_eaten,
  output logic                    eat_pulse,
  output logic                    busy
);

  localparam int IW = (N_DIAMOND > 1) ? $clog2(N_DIAMOND) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_DIAMOND - 1);
  localparam logic [10:0] DS_EXT = 11'(DIAMOND_SIZE);
  localparam logic [10:0] PW_EXT = 11'(PLAYER_W);
  localparam logic [10:0] PH_EXT = 11'(PLAYER_H);

  typedef enum logic [1:0] {IDLE, LATCH, CHECK, DONE} state_e;

  state_e                 state_q, state_d;
  logic                   syncA_q, syncB_q, syncPrev_q;
  logic                   frameTick;
  logic [9:0]             px_q, px_d;
  logic [9:0]             py_q, py_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [N_DIAMOND-1:0]   eaten_q, eaten_d;
  logic [3:0]             count_q, count_d;
  logic                   allEaten_q, allEaten_d;
  logic                   pulse_q, pulse_d;
  logic [9:0]             dxCur, dyCur;
  logic                   hit;

  // Two-flop synchronizer for the asynchronous frame strobe, plus a third
  // flop so a frame produces a single-cycle tick on its rising edge. These
  // flops are deliberately untouched by level_reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      syncA_q    <= 1'b0;
      syncB_q    <= 1'b0;
      syncPrev_q <= 1'b0;
    end else begin
      syncA_q    <= frame_clk;
      syncB_q    <= syncA_q;
      syncPrev_q <= syncB_q;
    end
  end

  assign frameTick = syncB_q & ~syncPrev_q;

  // Select the diamond addressed by the scan index. Diamond coordinates are
  // used live, not latched.
  always_comb begin
    dxCur = '0;
    dyCur = '0;
    for (int i = 0; i < N_DIAMOND; i++) begin
      if (idx_q == IW'(i)) begin
        dxCur = diamond_x[10*i +: 10];
        dyCur = diamond_y[10*i +: 10];
      end
    end
  end

  // Strict box-overlap test in 11 bits so edge sums never wrap; touching
  // edges do not count as overlap.
  assign hit = ({1'b0, px_q}  < ({1'b0, dxCur} + DS_EXT)) &&
               ({1'b0, dxCur} < ({1'b0, px_q}  + PW_EXT)) &&
               ({1'b0, py_q}  < ({1'b0, dyCur} + DS_EXT)) &&
               ({1'b0, dyCur} < ({1'b0, py_q}  + PH_EXT));

  // Scan FSM next-state and datapath. level_reset is applied last so it
  // overrides whatever the current state would have done.
  always_comb begin
    state_d    = state_q;
    px_d       = px_q;
    py_d       = py_q;
    idx_d      = idx_q;
    eaten_d    = eaten_q;
    count_d    = count_q;
    allEaten_d = allEaten_q;
    pulse_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (frameTick && game_active) state_d = LATCH;
      end
      LATCH: begin
        px_d    = player_x;
        py_d    = player_y;
        idx_d   = '0;
        state_d = CHECK;
      end
      CHECK: begin
        // An already-eaten diamond is skipped, so the count can never
        // exceed the number of diamonds.
        if (hit && !eaten_q[idx_q]) begin
          eaten_d[idx_q] = 1'b1;
          count_d        = count_q + 4'd1;
          pulse_d        = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        allEaten_d = &eaten_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (level_reset) begin
      state_d    = IDLE;
      eaten_d    = '0;
      count_d    = '0;
      allEaten_d = 1'b0;
      pulse_d    = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      px_q       <= '0;
      py_q       <= '0;
      idx_q      <= '0;
      eaten_q    <= '0;
      count_q    <= '0;
      allEaten_q <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      px_q       <= px_d;
      py_q       <= py_d;
      idx_q      <= idx_d;
      eaten_q    <= eaten_d;
      count_q    <= count_d;
      allEaten_q <= allEaten_d;
      pulse_q    <= pulse_d;
    end
  end

  assign is_diamond_eat = eaten_q;
  assign diamond_count  = count_q;
  assign all_eaten      = allEaten_q;
  assign eat_pulse      = pulse_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_diamond_eat_ctrl.sv
// tb_diamond_eat_ctrl
// Self-checking bench for diamond_eat_ctrl with the default 4-diamond level.
// A behavioural model keeps the set of eaten diamonds and the count; each
// scan is predicted from the box-overlap rule using plain integer math.
module tb_diamond_eat_ctrl;

  localparam int N = 4;

  logic           Clk = 1'b0;
  logic           Reset_n;
  logic           frame_clk;
  logic           level_reset;
  logic           game_active;
  logic [9:0]     player_x, player_y;
  logic [10*N-1:0] diamond_x, diamond_y;
  logic [N-1:0]   is_diamond_eat;
  logic [3:0]     diamond_count;
  logic           all_eaten, eat_pulse, busy;

  int checks = 0;
  int errors = 0;

  bit         mEaten[N];
  int         mCount;
  logic [9:0] dX[N];
  logic [9:0] dY[N];

  always #5 Clk = ~Clk;

  diamond_eat_ctrl #(
    .N_DIAMOND(N), .DIAMOND_SIZE(20), .PLAYER_W(20), .PLAYER_H(30)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .level_reset(level_reset), .game_active(game_active),
    .player_x(player_x), .player_y(player_y),
    .diamond_x(diamond_x), .diamond_y(diamond_y),
    .is_diamond_eat(is_diamond_eat), .diamond_count(diamond_count),
    .all_eaten(all_eaten), .eat_pulse(eat_pulse), .busy(busy)
  );

  // Overlap rule: player box (20x30) against a 20x20 diamond, strict edges.
  function automatic bit overlaps(int px, int py, int dx, int dy);
    return (px < dx + 20) && (dx < px + 20) && (py < dy + 20) && (dy < py + 30);
  endfunction

  function automatic logic [N-1:0] model_flags();
    logic [N-1:0] f;
    for (int i = 0; i < N; i++) f[i] = mEaten[i];
    return f;
  endfunction

  function automatic bit model_all();
    bit a = 1'b1;
    for (int i = 0; i < N; i++) a = a & mEaten[i];
    return a;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) mEaten[i] = 1'b0;
    mCount = 0;
  endtask

  task automatic model_scan(input int px, input int py, output int newEats);
    newEats = 0;
    for (int i = 0; i < N; i++) begin
      if (overlaps(px, py, int'(dX[i]), int'(dY[i])) && !mEaten[i]) begin
        mEaten[i] = 1'b1;
        mCount++;
        newEats++;
      end
    end
  endtask

  task automatic set_diamonds();
    for (int i = 0; i < N; i++) begin
      diamond_x[10*i +: 10] = dX[i];
      diamond_y[10*i +: 10] = dY[i];
    end
  endtask

  task automatic do_level_reset();
    level_reset = 1'b1;
    @(negedge Clk);
    level_reset = 1'b0;
    model_clear();
  endtask

  // Raises frame_clk for two cycles and observes a fixed 20-cycle window.
  // extraRise > 0 adds a second frame_clk rise at that cycle. With scramble
  // set, the player inputs are randomized once the scan is in CHECK.
  task automatic run_frame(input int extraRise, input bit scramble,
                           output int busyCycles, output int busyRises,
                           output int pulses, output int firstEdge);
    bit prevBusy = 1'b0;
    busyCycles = 0; busyRises = 0; pulses = 0; firstEdge = -1;
    for (int k = 0; k < 20; k++) begin
      if (k == 0) frame_clk = 1'b1;
      if (k == 2) frame_clk = 1'b0;
      if (extraRise > 0 && k == extraRise) frame_clk = 1'b1;
      if (extraRise > 0 && k == extraRise + 2) frame_clk = 1'b0;
      @(negedge Clk);
      if (busy === 1'b1) begin
        busyCycles++;
        if (!prevBusy) begin
          busyRises++;
          if (firstEdge < 0) firstEdge = k + 1;
        end
        if (scramble && busyCycles == 2) begin
          player_x = 10'($urandom_range(0, 1023));
          player_y = 10'($urandom_range(0, 1023));
        end
      end
      if (eat_pulse === 1'b1) pulses++;
      prevBusy = (busy === 1'b1);
    end
  endtask

  task automatic test_reset();
    int busySeen = 0;
    Reset_n = 1'b0; frame_clk = 1'b0; level_reset = 1'b0; game_active = 1'b0;
    player_x = '0; player_y = '0;
    for (int i = 0; i < N; i++) begin dX[i] = '0; dY[i] = '0; end
    set_diamonds();
    model_clear();
    #2;
    checks++;
    if ({is_diamond_eat, diamond_count, all_eaten, eat_pulse, busy} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 0",
               {is_diamond_eat, diamond_count, all_eaten, eat_pulse, busy});
    end
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      frame_clk = 1'b1;
      repeat (3) begin @(negedge Clk); if (busy !== 1'b0) busySeen++; end
      frame_clk = 1'b0;
      repeat (3) begin @(negedge Clk); if (busy !== 1'b0) busySeen++; end
    end
    checks++;
    if (busySeen !== 0) begin
      errors++;
      $display("[TB] FAIL idle_busy: got %0d busy cycles expected 0", busySeen);
    end
    checks++;
    if ({is_diamond_eat, diamond_count, all_eaten, eat_pulse} !== '0) begin
      errors++;
      $display("[TB] FAIL idle_outputs: got %b expected 0",
               {is_diamond_eat, diamond_count, all_eaten, eat_pulse});
    end
  endtask

  task automatic test_single_eat();
    int bc, br, pc, fe, ne;
    do_level_reset();
    game_active = 1'b1;
    dX[0] = 10'd458; dY[0] = 10'd408;
    for (int i = 1; i < N; i++) begin dX[i] = '0; dY[i] = '0; end
    set_diamonds();
    player_x = 10'd450; player_y = 10'd400;
    model_scan(450, 400, ne);
    run_frame(0, 1'b0, bc, br, pc, fe);
    checks++;
    if (bc !== 6) begin errors++; $display("[TB] FAIL single_busy_len: got %0d expected 6", bc); end
    checks++;
    if (fe !== 3) begin errors++; $display("[TB] FAIL single_latency: got %0d expected 3", fe); end
    checks++;
    if (is_diamond_eat !== 4'b0001) begin
      errors++; $display("[TB] FAIL single_flags: got %b expected 0001", is_diamond_eat);
    end
    checks++;
    if (diamond_count !== 4'd1) begin
      errors++; $display("[TB] FAIL single_count: got %0d expected 1", diamond_count);
    end
    checks++;
    if (pc !== ne) begin errors++; $display("[TB] FAIL single_pulses: got %0d expected %0d", pc, ne); end
  endtask

  task automatic test_edge_touch();
    int bc, br, pc, fe, ne;
    int px[3] = '{438, 439, 439};
    int expCount[3] = '{0, 1, 1};
    int expPulse[3] = '{0, 1, 0};
    do_level_reset();
    for (int f = 0; f < 3; f++) begin
      player_x = 10'(px[f]); player_y = 10'd408;
      model_scan(px[f], 408, ne);
      run_frame(0, 1'b0, bc, br, pc, fe);
      checks++;
      if (diamond_count !== 4'(expCount[f])) begin
        errors++;
        $display("[TB] FAIL edge_count[%0d]: got %0d expected %0d", f, diamond_count, expCount[f]);
      end
      checks++;
      if (pc !== expPulse[f] || pc !== ne) begin
        errors++;
        $display("[TB] FAIL edge_pulse[%0d]: got %0d expected %0d", f, pc, expPulse[f]);
      end
      checks++;
      if (is_diamond_eat !== model_flags()) begin
        errors++;
        $display("[TB] FAIL edge_flags[%0d]: got %b expected %b", f, is_diamond_eat, model_flags());
      end
    end
  endtask

  task automatic test_all_eaten();
    int bc, br, pc, fe, ne;
    int total = 0;
    do_level_reset();
    for (int i = 0; i < N; i++) begin dX[i] = 10'(100 + 100*i); dY[i] = 10'd100; end
    set_diamonds();
    for (int i = 0; i < N; i++) begin
      player_x = dX[i] + 10'd5; player_y = 10'd100;
      model_scan(int'(dX[i]) + 5, 100, ne);
      run_frame(0, 1'b0, bc, br, pc, fe);
      total += pc;
      checks++;
      if (all_eaten !== model_all()) begin
        errors++; $display("[TB] FAIL all_flag[%0d]: got %0d expected %0d", i, all_eaten, model_all());
      end
      checks++;
      if (diamond_count !== 4'(mCount)) begin
        errors++; $display("[TB] FAIL all_count[%0d]: got %0d expected %0d", i, diamond_count, mCount);
      end
    end
    checks++;
    if (diamond_count !== 4'd4 || all_eaten !== 1'b1) begin
      errors++;
      $display("[TB] FAIL all_final: got count %0d all %0d expected 4 1", diamond_count, all_eaten);
    end
    checks++;
    if (total !== 4) begin errors++; $display("[TB] FAIL all_pulses: got %0d expected 4", total); end
  endtask

  task automatic test_level_reset();
    int bc, br, pc, fe, ne;
    int scanBusy = 0, pulsesAfter = 0, busyAfter = 0;
    bit applied = 1'b0;
    do_level_reset();
    dX[0] = 10'd100; dY[0] = 10'd100;
    dX[1] = 10'd115; dY[1] = 10'd100;
    dX[2] = 10'd300; dY[2] = 10'd300;
    dX[3] = 10'd0;   dY[3] = 10'd0;
    set_diamonds();
    player_x = 10'd105; player_y = 10'd100;
    model_scan(105, 100, ne);
    run_frame(0, 1'b0, bc, br, pc, fe);
    checks++;
    if (diamond_count !== 4'd2) begin
      errors++; $display("[TB] FAIL lr_setup_count: got %0d expected 2", diamond_count);
    end
    player_x = 10'd300; player_y = 10'd300;
    frame_clk = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k == 2) frame_clk = 1'b0;
      @(negedge Clk);
      if (applied) begin
        if (busy !== 1'b0) busyAfter++;
        if (eat_pulse !== 1'b0) pulsesAfter++;
      end else if (busy === 1'b1) begin
        scanBusy++;
        if (scanBusy == 4) begin
          level_reset = 1'b1;
          @(negedge Clk);
          level_reset = 1'b0;
          model_clear();
          applied = 1'b1;
          checks++;
          if ({is_diamond_eat, diamond_count, all_eaten, busy} !== '0) begin
            errors++;
            $display("[TB] FAIL lr_clear: got %b expected 0",
                     {is_diamond_eat, diamond_count, all_eaten, busy});
          end
        end
      end
    end
    checks++;
    if (!applied) begin errors++; $display("[TB] FAIL lr_reach_check2: got 0 expected 1"); end
    checks++;
    if (pulsesAfter !== 0 || busyAfter !== 0) begin
      errors++;
      $display("[TB] FAIL lr_after: got pulses %0d busy %0d expected 0 0", pulsesAfter, busyAfter);
    end
  endtask

  task automatic test_back_to_back();
    int bc, br, pc, fe, ne;
    do_level_reset();
    player_x = 10'd105; player_y = 10'd100;
    model_scan(105, 100, ne);
    run_frame(3, 1'b0, bc, br, pc, fe);
    checks++;
    if (br !== 1 || bc !== 6) begin
      errors++; $display("[TB] FAIL dropped_tick: got scans %0d busy %0d expected 1 6", br, bc);
    end
    checks++;
    if (pc !== ne || diamond_count !== 4'(mCount)) begin
      errors++;
      $display("[TB] FAIL dropped_eats: got pulses %0d count %0d expected %0d %0d",
               pc, diamond_count, ne, mCount);
    end
  endtask

  task automatic test_async_reset();
    int seen = 0;
    bit hit = 1'b0;
    player_x = 10'd300; player_y = 10'd300;
    frame_clk = 1'b1;
    for (int k = 0; k < 20 && !hit; k++) begin
      if (k == 2) frame_clk = 1'b0;
      @(negedge Clk);
      if (busy === 1'b1) seen++;
      if (seen == 3) begin
        Reset_n = 1'b0;
        #1;
        hit = 1'b1;
        checks++;
        if ({is_diamond_eat, diamond_count, all_eaten, eat_pulse, busy} !== '0) begin
          errors++;
          $display("[TB] FAIL async_reset: got %b expected 0",
                   {is_diamond_eat, diamond_count, all_eaten, eat_pulse, busy});
        end
      end
    end
    frame_clk = 1'b0;
    checks++;
    if (!hit) begin errors++; $display("[TB] FAIL async_reach_check: got 0 expected 1"); end
    @(negedge Clk);
    Reset_n = 1'b1;
    model_clear();
    @(negedge Clk);
  endtask

  task automatic test_random();
    int bc, br, pc, fe, ne, px, py;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 7) == 0) do_level_reset();
      game_active = ($urandom_range(0, 9) != 0);
      px = int'($urandom_range(100, 300));
      py = int'($urandom_range(100, 300));
      for (int i = 0; i < N; i++) begin
        dX[i] = 10'(px + int'($urandom_range(0, 70)) - 35);
        dY[i] = 10'(py + int'($urandom_range(0, 80)) - 45);
      end
      set_diamonds();
      player_x = 10'(px); player_y = 10'(py);
      ne = 0;
      if (game_active) model_scan(px, py, ne);
      run_frame(0, 1'b1, bc, br, pc, fe);
      checks++;
      if (br !== (game_active ? 1 : 0)) begin
        errors++; $display("[TB] FAIL rand_scan[%0d]: got %0d expected %0d", it, br, game_active ? 1 : 0);
      end
      checks++;
      if (pc !== ne) begin errors++; $display("[TB] FAIL rand_pulses[%0d]: got %0d expected %0d", it, pc, ne); end
      checks++;
      if (is_diamond_eat !== model_flags() || diamond_count !== 4'(mCount) || all_eaten !== model_all()) begin
        errors++;
        $display("[TB] FAIL rand_state[%0d]: got %b/%0d/%0d expected %b/%0d/%0d", it,
                 is_diamond_eat, diamond_count, all_eaten, model_flags(), mCount, model_all());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_eat();
    test_edge_touch();
    test_all_eaten();
    test_level_reset();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/diamond_eat_ctrl.md
# diamond_eat_ctrl

Per-level diamond collection controller. Once per video frame it latches the player's position and scans the level's N diamonds one per clock. Each diamond the player box overlaps is marked eaten. The sticky eaten flags drive the per-diamond `is_diamond_eat*` inputs of the diamond sprite display blocks; the block also keeps a collected count for the score and level-exit logic.

## Interface
Parameters:
- `N_DIAMOND`, 4: number of diamonds in the level (1..8).
- `DIAMOND_SIZE`, 20: diamond sprite edge in pixels (square).
- `PLAYER_W`, 20: player hitbox width in pixels.
- `PLAYER_H`, 30: player hitbox height in pixels.

Ports:
- `Clk`  in  1  system clock; the one clock for the whole block.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `frame_clk`  in  1  vsync-derived frame strobe; asynchronous to `Clk`, synchronized internally.
- `level_reset`  in  1  synchronous clear of all eaten state; used on level restart.
- `game_active`  in  1  scans are started only while high.
- `player_x`  in  10  player hitbox left edge in pixels.
- `player_y`  in  10  player hitbox top edge in pixels.
- `diamond_x`  in  10*N_DIAMOND  packed diamond left edges; diamond i is at bits [10i+9:10i].
- `diamond_y`  in  10*N_DIAMOND  packed diamond top edges, same packing.
- `is_diamond_eat`  out  N_DIAMOND  sticky eaten flag per diamond.
- `diamond_count`  out  4  number of diamonds eaten.
- `all_eaten`  out  1  high when every diamond is eaten.
- `eat_pulse`  out  1  one-cycle strobe for each newly eaten diamond.
- `busy`  out  1  high while a scan is in progress.

## Operation
- `frame_clk` passes through a 2-flop synchronizer. A frame tick is a rising edge of the synchronized signal, detected with a third flop.
- FSM states: IDLE, LATCH, CHECK, DONE.
  - IDLE → LATCH on a frame tick when `game_active` = 1. A tick with `game_active` = 0 is ignored.
  - LATCH: register `player_x` and `player_y`; clear the scan index to 0; go to CHECK.
  - CHECK: test diamond[index]. On `index == N_DIAMOND-1`, go to DONE; otherwise increment the index and stay in CHECK.
  - DONE: recompute `all_eaten`; go to IDLE.
- Overlap test for diamond i:
  - All sums are computed zero-extended to 11 bits, so they never wrap.
  - The test passes when all four conditions hold: `px < dx+DIAMOND_SIZE`, `dx < px+PLAYER_W`, `py < dy+DIAMOND_SIZE`, `dy < py+PLAYER_H`.
  - Edges that only touch do not overlap; the comparisons are strict.
- On a passing overlap where `is_diamond_eat[i]` = 0:
  - set `is_diamond_eat[i]`;
  - increment `diamond_count`;
  - assert `eat_pulse` on the following cycle.
- An already-eaten diamond is never re-counted. `diamond_count` cannot exceed `N_DIAMOND` and does not saturate past it.
- Diamond coordinates are sampled live during CHECK. Player coordinates are the values latched in LATCH; later changes within the scan have no effect.
- `level_reset` has priority over everything else. In the cycle it is high:
  - `is_diamond_eat`, `diamond_count`, `all_eaten` and `eat_pulse` are cleared;
  - the FSM is forced to IDLE, aborting any scan.
- Frame ticks that arrive while `busy` = 1 are dropped, not queued.

## Timing
- Reset values: `is_diamond_eat` = 0, `diamond_count` = 0, `all_eaten` = 0, `eat_pulse` = 0, `busy` = 0, FSM = IDLE, synchronizer flops = 0.
- `frame_clk` rise to LATCH: 3 `Clk` edges (2 synchronizer stages plus 1 edge-detect).
- Scan length: LATCH (1 cycle) + CHECK (`N_DIAMOND` cycles) + DONE (1 cycle). That is 6 cycles for the default `N_DIAMOND` = 4.
- `busy` is high in LATCH, CHECK and DONE.
- Diamond i's flag and count update is registered at the end of CHECK cycle i. Both are visible in the next cycle, together with the `eat_pulse` strobe.
- `all_eaten` is registered at the end of DONE, so it lags the last flag by at most `N_DIAMOND` cycles.
- Outputs are registered and constant between scans, so display logic can sample them at any time.
- Reset asserted mid-scan: all state returns to reset values immediately, without waiting for a clock edge.

## Test plan
- Reset and idle: hold `Reset_n` = 0, then release with `game_active` = 0 and toggle `frame_clk` 3 times. Required: all outputs stay 0 and `busy` never rises.
- Single eat:
  - Stimulus: diamond0 at (458,408), other diamonds at (0,0); player at (450,400); `game_active` = 1; one `frame_clk` rise.
  - Required: `busy` is high for 6 cycles; `is_diamond_eat` = 4'b0001; `diamond_count` = 1; exactly one `eat_pulse`.
- Edge touch and no re-count:
  - With the player at (438,408) (right edge = diamond left edge), one frame: no eat.
  - Then move to (439,408) for two frames. Required: the eat happens on the first frame; `diamond_count` stays 1 and there is no `eat_pulse` on the second frame.
- All eaten: place the player so its box covers diamonds 0–3 across successive frames. Required: `diamond_count` = 4, `all_eaten` = 1 after the final DONE, and 4 `eat_pulse` strobes in total.
- `level_reset` mid-scan: assert `level_reset` for 1 cycle during CHECK index 2 while 2 diamonds are eaten. Required: flags, count and `all_eaten` go to 0, the FSM returns to IDLE, and no pulse follows.
- Dropped tick and async reset: issue a second `frame_clk` rise while `busy` = 1; the required response is exactly one scan. Then drop `Reset_n` mid-CHECK; all outputs must read 0 before the next `Clk` edge.
